// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO shift register.
// PISO_SHIFT_REG_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bits per serial frame: the data word plus the optional parity bit.
  function automatic int frame_len(input int width);
`ifdef PISO_SHIFT_REG_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int cnt_width(input int flen);
    return (flen <= 1) ? 1 : $clog2(flen);
  endfunction

  localparam int CNT_W_MAX = cnt_width(frame_len(64));

endpackage

// File: rtl/piso_shift_reg_if.sv
// Parallel-load and serial-out handshake bundle for piso_shift_reg.
// master = producer/consumer harness, slave = the shift register.
interface piso_shift_reg_if #(
  parameter int WIDTH = 23
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_ready;
  logic             ser_valid;
  logic             ser_out;
  logic             ser_first;
  logic             ser_last;

  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_valid, ser_out, ser_first, ser_last
  );

  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_valid, ser_out, ser_first, ser_last
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with zero flag; load has priority, saturates at 0.
// Single-cycle update, no handshake of its own.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int W = CNT_W_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter; first bit one cycle after load, optional parity (PISO_SHIFT_REG_PARITY_EN).
// Bits advance only on ser_valid&&ser_ready; reloads on the last-bit beat for gap-free frames.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int WIDTH     = 23,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  piso_shift_reg_if.slave bus
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = cnt_width(FRAME_LEN);

  state_e               state_q;
  state_e               state_d;
  logic [FRAME_LEN-1:0] shreg_q;
  logic                 first_q;
  logic [WIDTH-1:0]     word_ord;
  logic [FRAME_LEN-1:0] frame_init;
  logic                 cnt_zero;
  logic                 load_fire;
  logic                 adv;
  logic                 ld_rdy;

  // The head bit is always shreg_q[FRAME_LEN-1]; bit order is fixed at load.
  always_comb begin
    word_ord = bus.load_data;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        word_ord[i] = bus.load_data[WIDTH-1-i];
      end
    end
  end

`ifdef PISO_SHIFT_REG_PARITY_EN
  assign frame_init = {word_ord, ^bus.load_data};
`else
  assign frame_init = word_ord;
`endif

  always_comb begin
    state_d   = state_q;
    load_fire = 1'b0;
    adv       = 1'b0;
    ld_rdy    = 1'b0;
    case (state_q)
      IDLE: begin
        ld_rdy = 1'b1;
        if (bus.load_valid) begin
          load_fire = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        adv       = bus.ser_ready;
        ld_rdy    = cnt_zero && bus.ser_ready;
        load_fire = ld_rdy && bus.load_valid;
        if (adv && cnt_zero) begin
          state_d = bus.load_valid ? SHIFT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_fire) begin
        shreg_q <= frame_init;
        first_q <= 1'b1;
      end else if (adv) begin
        shreg_q <= {shreg_q[FRAME_LEN-2:0], 1'b0};
        first_q <= 1'b0;
      end
    end
  end

  piso_bit_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_fire),
    .load_val (CNT_W'(FRAME_LEN - 1)),
    .dec      (adv),
    .zero     (cnt_zero)
  );

  assign bus.load_ready = ld_rdy;
  assign bus.ser_valid  = (state_q == SHIFT);
  assign bus.ser_out    = shreg_q[FRAME_LEN-1];
  assign bus.ser_first  = first_q;
  assign bus.ser_last   = (state_q == SHIFT) && cnt_zero;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: three instances (8b MSB-first, 8b LSB-first, 23b MSB-first)
// checked cycle by cycle against a frame-level bit-queue model.
module tb_piso_shift_reg;

`ifdef PISO_SHIFT_REG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        lv    = 1'b0;
  logic        sr    = 1'b0;
  logic [63:0] ld    = '0;
  int          sel   = 0;
  int          total = 0;
  int          passed = 0;
  int          consumed = 0;
  logic [63:0] wq[$];

  always #5 clk = ~clk;

  piso_shift_reg_if #(.WIDTH(8))  ifa ();
  piso_shift_reg_if #(.WIDTH(8))  ifb ();
  piso_shift_reg_if #(.WIDTH(23)) ifc ();

  piso_shift_reg #(.WIDTH(8),  .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  piso_shift_reg #(.WIDTH(8),  .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  piso_shift_reg #(.WIDTH(23), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  assign ifa.load_valid = lv && (sel == 0);
  assign ifa.load_data  = ld[7:0];
  assign ifa.ser_ready  = sr && (sel == 0);
  assign ifb.load_valid = lv && (sel == 1);
  assign ifb.load_data  = ld[7:0];
  assign ifb.ser_ready  = sr && (sel == 1);
  assign ifc.load_valid = lv && (sel == 2);
  assign ifc.load_data  = ld[22:0];
  assign ifc.ser_ready  = sr && (sel == 2);

  logic o_vld, o_rdy, o_out, o_first, o_last;
  always_comb begin
    o_vld = ifa.ser_valid; o_rdy = ifa.load_ready; o_out = ifa.ser_out;
    o_first = ifa.ser_first; o_last = ifa.ser_last;
    if (sel == 1) begin
      o_vld = ifb.ser_valid; o_rdy = ifb.load_ready; o_out = ifb.ser_out;
      o_first = ifb.ser_first; o_last = ifb.ser_last;
    end else if (sel == 2) begin
      o_vld = ifc.ser_valid; o_rdy = ifc.load_ready; o_out = ifc.ser_out;
      o_first = ifc.ser_first; o_last = ifc.ser_last;
    end
  end

  function automatic int sel_w();
    return (sel == 2) ? 23 : 8;
  endfunction

  function automatic bit sel_msb();
    return sel != 1;
  endfunction

  // i-th transmitted bit of a frame: data in the chosen order, then even parity.
  function automatic logic model_bit(input logic [63:0] d, input int w, input bit msb, input int i);
    int ones;
    ones = 0;
    if (i < w) return msb ? d[w-1-i] : d[i];
    for (int k = 0; k < w; k++) ones += int'(d[k]);
    return logic'(ones % 2);
  endfunction

  // Feeds wq[0..nwords-1] with random producer gaps and consumer stalls,
  // comparing every cycle against the expected bit queue.
  task automatic stream(input int nwords, input int gap_pct, input int stall_pct);
    exp_t exq[$];
    exp_t cur;
    int   pos = 0;
    int   widx = 0;
    int   budget = 0;
    int   fl;
    bit   evld, elr, lfire, sfire;
    fl = sel_w() + PAR;
    consumed = 0;
    lfire = 0;
    while ((widx < nwords || pos < exq.size()) && budget < 5000) begin
      budget++;
      @(negedge clk);
      if (lfire) lv = 1'b0;
      if (!lv && widx < nwords && $urandom_range(99) >= gap_pct) begin
        lv = 1'b1;
        ld = wq[widx];
      end
      sr = ($urandom_range(99) >= stall_pct);
      #1;
      evld = pos < exq.size();
      cur  = evld ? exq[pos] : '0;
      elr  = !evld || (cur.last && sr);
      total++;
      if (o_vld !== evld) $display("FAIL ser_valid: got %0b expected %0b (bit %0d)", o_vld, evld, pos);
      else passed++;
      if (evld) begin
        total++;
        if (o_out !== cur.b) $display("FAIL ser_out: got %0b expected %0b (bit %0d)", o_out, cur.b, pos);
        else passed++;
        total++;
        if (o_first !== cur.first) $display("FAIL ser_first: got %0b expected %0b (bit %0d)", o_first, cur.first, pos);
        else passed++;
        total++;
        if (o_last !== cur.last) $display("FAIL ser_last: got %0b expected %0b (bit %0d)", o_last, cur.last, pos);
        else passed++;
      end
      total++;
      if (o_rdy !== elr) $display("FAIL load_ready: got %0b expected %0b (bit %0d)", o_rdy, elr, pos);
      else passed++;
      lfire = lv && elr;
      sfire = evld && sr;
      @(posedge clk);
      if (sfire) begin
        pos++;
        consumed++;
      end
      if (lfire) begin
        for (int i = 0; i < fl; i++) begin
          exq.push_back('{b: model_bit(wq[widx], sel_w(), sel_msb(), i),
                          first: (i == 0), last: (i == fl - 1)});
        end
        widx++;
      end
    end
    @(negedge clk);
    lv = 1'b0;
    #1;
    total++;
    if (budget >= 5000) $display("FAIL stream_timeout: got %0d cycles expected completion", budget);
    else passed++;
    total++;
    if (o_vld !== 1'b0 || o_out !== 1'b0)
      $display("FAIL idle_after_stream: got valid=%0b out=%0b expected 0/0", o_vld, o_out);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lv = 1'b0; sr = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++;
      if ({o_vld, o_out, o_first, o_last, o_rdy} !== 5'b00001)
        $display("FAIL reset_outputs[%0d]: got %05b expected 00001", s, {o_vld, o_out, o_first, o_last, o_rdy});
      else passed++;
    end
    rst_n = 1'b1;
    sel = 0;
    @(negedge clk);
    #1;
    total++;
    if (o_vld !== 1'b0 || o_rdy !== 1'b1)
      $display("FAIL post_reset_idle: got valid=%0b ready=%0b expected 0/1", o_vld, o_rdy);
    else passed++;
  endtask

  task automatic test_msb_first();
    sel = 0;
    wq = '{64'hA5};
    stream(1, 0, 0);
    total++;
    if (consumed !== 8 + PAR) $display("FAIL msb_frame_len: got %0d expected %0d", consumed, 8 + PAR);
    else passed++;
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back(64'($urandom_range(255)));
    stream(6, 40, 20);
  endtask

  task automatic test_lsb_first();
    sel = 1;
    wq = '{64'hA5, 64'h01, 64'h80};
    stream(3, 0, 0);
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back(64'($urandom_range(255)));
    stream(6, 30, 30);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    wq = '{64'hFF, 64'h00};
    stream(2, 0, 0);
    total++;
    if (consumed !== 2 * (8 + PAR)) $display("FAIL b2b_bits: got %0d expected %0d", consumed, 2 * (8 + PAR));
    else passed++;
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(64'($urandom_range(255)));
    stream(8, 0, 25);
  endtask

  task automatic test_stall();
    sel = 2;
    wq = '{64'h5A5A5A};
    stream(1, 0, 0);
    stream(1, 0, 35);
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back({41'd0, 23'($urandom)});
    stream(5, 20, 40);
    total++;
    if (consumed !== 5 * (23 + PAR)) $display("FAIL stall_bits: got %0d expected %0d", consumed, 5 * (23 + PAR));
    else passed++;
  endtask

  task automatic test_reset_mid();
    sel = 0;
    @(negedge clk);
    lv = 1'b1; ld = 64'h3C; sr = 1'b1;
    @(negedge clk);
    lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (o_vld !== 1'b1 || o_out !== model_bit(64'h3C, 8, 1'b1, i))
        $display("FAIL mid_pre_bit%0d: got valid=%0b out=%0b expected 1/%0b", i, o_vld, o_out, model_bit(64'h3C, 8, 1'b1, i));
      else passed++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({o_vld, o_out, o_first, o_last, o_rdy} !== 5'b00001)
      $display("FAIL mid_reset_state: got %05b expected 00001", {o_vld, o_out, o_first, o_last, o_rdy});
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (o_vld !== 1'b0) $display("FAIL mid_reset_no_bits: got %0b expected 0", o_vld);
    else passed++;
    wq = '{64'hC3};
    stream(1, 0, 0);
  endtask

  task automatic test_parity_frame();
    sel = 0;
    wq = '{64'h07};
    stream(1, 0, 0);
    total++;
    if (consumed !== 8 + PAR) $display("FAIL parity_frame_len: got %0d expected %0d", consumed, 8 + PAR);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_parity_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- Parallel-in serial-out shift register; the transmit-side counterpart of the team's SIPO shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per accepted serial cycle.
- Provides frame markers so a downstream SIPO, or its harness, can reassemble words.
- Sits between a parallel producer and a serial link or SIPO under test.

Parameters:
- WIDTH, 23, word width in bits; legal range 2..64.
- MSB_FIRST, 1, bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block can accept a word.
- load_data  in  WIDTH  parallel word.
- ser_ready  in  1  downstream consumes ser_out this cycle.
- ser_valid  out  1  ser_out holds a valid bit.
- ser_out  out  1  serial data bit.
- ser_first  out  1  current bit is the first of its word.
- ser_last  out  1  current bit is the last of its frame.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State returns to IDLE; shift register and bit counter clear.
  - ser_valid=0, ser_out=0, ser_first=0, ser_last=0, load_ready=1.
  - Reset mid-word abandons the word; no further bits are emitted.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, ser_valid=0.
  - load_valid&&load_ready at an edge: capture load_data, counter=FRAME_LEN-1, go to SHIFT.
- SHIFT:
  - ser_valid=1; ser_out is the current head bit.
  - ser_first=1 only while the first bit of the frame is presented.
  - ser_last=1 when counter==0.
- Output latency: the first bit appears on ser_out the cycle after the load handshake; this is a registered output.
- Advance: only on edges with ser_valid&&ser_ready.
  - Shift toward the head bit, fill with 0, decrement the counter.
- Stall: ser_ready=0 holds ser_out, ser_first, ser_last and the counter stable; bits are never dropped or duplicated.
- load_ready in SHIFT = ser_last&&ser_ready, giving back-to-back frames:
  - Load and last-bit consumption in the same cycle → the new word's first bit appears on the next cycle.
  - ser_valid stays 1 and there are no idle bubbles.
- Last bit consumed with no concurrent load → IDLE; ser_valid=0 next cycle.
- load_valid while load_ready=0 is ignored; the producer must hold its data (standard valid/ready).
- FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature enabled.
- Counter width = clog2(FRAME_LEN); it never wraps below 0.

Optional Feature:
- Macro: PISO_SHIFT_REG_PARITY_EN.
- Defined:
  - Even parity (XOR of load_data) is captured at load.
  - Parity is emitted as an extra bit after the data bits; ser_last marks the parity bit.
  - FRAME_LEN=WIDTH+1.
- Undefined: no parity logic; ser_last marks the final data bit; FRAME_LEN=WIDTH.

Decomposition:
- Package piso_pkg:
  - State enum {IDLE, SHIFT}.
  - Function frame_len(WIDTH).
  - Localparam for counter width.
- One natural sub-module: piso_bit_counter, a loadable down-counter with a zero flag, reused for the ser_last decode.
- Datapath and FSM stay in the top module.

Test Plan:
- WIDTH=8, MSB_FIRST=1, load 8'hA5, ser_ready=1 → ser_out 1,0,1,0,0,1,0,1 on cycles 1-8 after the handshake; ser_first on cycle 1, ser_last on cycle 8; ser_valid=0 on cycle 9.
- MSB_FIRST=0, load 8'hA5 → LSB first: 1,0,1,0,0,1,0,1 reversed order check (1,0,1,0,0,1,0,1 read bit0..bit7); ser_first and ser_last positions are unchanged.
- Back-to-back loads of 8'hFF then 8'h00 with load_valid held → exactly 16 contiguous valid bits (8 ones, then 8 zeros); ser_valid never drops; load_ready pulses only on the last-bit cycle.
- ser_ready toggled randomly, 3 stall cycles mid-word on 23'h5A5A5A → the bit sequence is identical to the unstalled run; outputs are stable during stalls.
- rst_n low for 1 cycle at bit 4 of 8'h3C → the next cycle shows ser_valid=0 and load_ready=1; a subsequent load of 8'hC3 serialises correctly from bit 0.
- PISO_SHIFT_REG_PARITY_EN defined, load 8'h07 → 9 bits are emitted; the 9th bit=1 (odd popcount gives even-parity bit 1) with ser_last asserted on it.
